// File: rtl/pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter
//
// Central round-robin arbiter for a shared PCI-style bus. Grants the bus to one
// requesting master at a time, tracks the transaction through iframe/iready and
// withdraws a grant the master never used within GNT_TIMEOUT cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   request      per-master bus request, active low
//   iframe       shared frame, active low
//   iready       shared initiator ready, active low
//   grant        per-master grant, active low, at most one bit low
//   bus_owner    index of the granted/owning master, valid while grant_valid
//   grant_valid  high while any grant bit is low
//   bus_busy     high while a transaction is in flight
//   timeout      one-cycle pulse when an unused grant is withdrawn
// -----------------------------------------------------------------------------
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int OWNER_W     = 2,
  parameter int GNT_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   iframe,
  input  logic                   iready,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [OWNER_W-1:0]     bus_owner,
  output logic                   grant_valid,
  output logic                   bus_busy,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY,
    TURNAROUND
  } state_t;

  localparam logic [7:0]         TIMER_MAX  = 8'(GNT_TIMEOUT - 1);
  localparam logic [OWNER_W-1:0] LAST_RESET = OWNER_W'(NUM_MASTERS - 1);

  state_t                 state, state_nxt;
  logic [OWNER_W-1:0]     last_owner, last_owner_nxt;
  logic [OWNER_W-1:0]     bus_owner_nxt;
  logic [7:0]             timer, timer_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic                   grant_valid_nxt, bus_busy_nxt, timeout_nxt;

  logic [OWNER_W-1:0]     winner, rr_idx;
  logic [NUM_MASTERS-1:0] winner_grant;
  logic                   req_any;
  logic                   bus_idle;

  assign bus_idle = iframe & iready;

  // Round-robin search starting just after the last owner. Walking the
  // offsets from farthest to nearest lets the nearest requester overwrite
  // any earlier hit, so the first match in search order wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    winner       = '0;
    req_any      = 1'b0;
    rr_idx       = '0;
    winner_grant = '1;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      rr_idx = OWNER_W'((int'(last_owner) + i) % NUM_MASTERS);
      if (!request[rr_idx]) begin
        winner  = rr_idx;
        req_any = 1'b1;
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      winner_grant[j] = (OWNER_W'(j) != winner);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    bus_owner_nxt   = bus_owner;
    grant_valid_nxt = grant_valid;
    bus_busy_nxt    = bus_busy;
    timeout_nxt     = 1'b0;
    last_owner_nxt  = last_owner;
    timer_nxt       = timer;

    case (state)
      IDLE: begin
        // No parking: the bus is only granted to an active requester.
        if (req_any && bus_idle) begin
          grant_nxt       = winner_grant;
          bus_owner_nxt   = winner;
          grant_valid_nxt = 1'b1;
          timer_nxt       = '0;
          state_nxt       = GRANTED;
        end
      end

      GRANTED: begin
        // Transaction start outranks a request drop or a timeout in the
        // same cycle.
        if (!iframe) begin
          bus_busy_nxt   = 1'b1;
          last_owner_nxt = bus_owner;
          state_nxt      = BUSY;
        end else if (request[bus_owner]) begin
          grant_nxt       = '1;
          grant_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end else if (timer == TIMER_MAX) begin
          // The idle master also loses priority, so a stuck requester
          // cannot starve the others.
          grant_nxt       = '1;
          grant_valid_nxt = 1'b0;
          timeout_nxt     = 1'b1;
          last_owner_nxt  = bus_owner;
          state_nxt       = IDLE;
        end else if (timer < TIMER_MAX) begin
          timer_nxt = timer + 8'd1;
        end
      end

      BUSY: begin
        // Held until the bus returns idle; other requests wait.
        if (bus_idle) begin
          grant_nxt       = '1;
          grant_valid_nxt = 1'b0;
          bus_busy_nxt    = 1'b0;
          state_nxt       = TURNAROUND;
        end
      end

      TURNAROUND: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '1;
      bus_owner   <= '0;
      grant_valid <= 1'b0;
      bus_busy    <= 1'b0;
      timeout     <= 1'b0;
      last_owner  <= LAST_RESET;
      timer       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_nxt;
      grant       <= grant_nxt;
      bus_owner   <= bus_owner_nxt;
      grant_valid <= grant_valid_nxt;
      bus_busy    <= bus_busy_nxt;
      timeout     <= timeout_nxt;
      last_owner  <= last_owner_nxt;
      timer       <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_bus_arbiter
//
// Directed bench for pci_bus_arbiter (3 masters, timeout 8). The stimulus
// process pushes each expected output change, with the cycle it must appear
// in, onto a queue. A monitor samples the outputs just after every falling
// clock edge (and on reset assertion), pops an entry whenever the
// grant/grant_valid/bus_busy/timeout tuple changes and compares. The monitor
// also checks the output invariants on every sample.
// -----------------------------------------------------------------------------
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] request;
  logic       iframe;
  logic       iready;
  logic [2:0] grant;
  logic [1:0] bus_owner;
  logic       grant_valid;
  logic       bus_busy;
  logic       timeout;

  int cyc     = 0;
  int n_checks = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [2:0] grant;
    int         owner;
    bit         gv;
    bit         busy;
    bit         tmo;
    int         at;     // cycle the change must appear in, -1 = any
  } ev_t;

  ev_t exp_q[$];

  // Hand-computed round-robin order from reset with all three requesting.
  localparam logic [2:0] RR_GRANT [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
  localparam int         RR_OWNER [4] = '{0, 1, 2, 0};

  pci_bus_arbiter #(
    .NUM_MASTERS(3),
    .OWNER_W    (2),
    .GNT_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .iframe     (iframe),
    .iready     (iready),
    .grant      (grant),
    .bus_owner  (bus_owner),
    .grant_valid(grant_valid),
    .bus_busy   (bus_busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic expect_ev(input string name, input logic [2:0] g, input int owner,
                           input bit gv, input bit busy, input bit tmo, input int at);
    ev_t e;
    e.name  = name;
    e.grant = g;
    e.owner = owner;
    e.gv    = gv;
    e.busy  = busy;
    e.tmo   = tmo;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  // Advance to the falling edge at which cyc == n.
  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [5:0] mon_prev;
  logic [5:0] mon_cur;
  logic       mon_prev_tmo;
  ev_t        mon_e;
  bit         mon_ok;

  initial begin : monitor
    mon_prev     = 'x;
    mon_prev_tmo = 1'b0;
    @(negedge clk);
    forever begin
      #1;
      mon_cur = {grant, grant_valid, bus_busy, timeout, 1'b0};
      check("grant_valid_vs_grant", grant_valid === ~&grant,
            $sformatf("got grant_valid=%b with grant=%b", grant_valid, grant));
      check("grant_one_low", $onehot0(~grant),
            $sformatf("got grant=%b, need at most one bit low", grant));
      check("timeout_single_cycle", !(timeout && mon_prev_tmo),
            $sformatf("timeout high on consecutive samples at cyc=%0d", cyc));
      mon_prev_tmo = timeout;
      if (mon_cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 1'b0,
                $sformatf("got grant=%b gv=%b busy=%b tmo=%b at cyc=%0d, no change expected",
                          grant, grant_valid, bus_busy, timeout, cyc));
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ok = (grant === mon_e.grant) && (grant_valid === mon_e.gv) &&
                   (bus_busy === mon_e.busy) && (timeout === mon_e.tmo) &&
                   (!mon_e.gv || bus_owner === 2'(mon_e.owner)) &&
                   (mon_e.at < 0 || mon_e.at == cyc);
          check(mon_e.name, mon_ok,
                $sformatf("got grant=%b owner=%0d gv=%b busy=%b tmo=%b cyc=%0d, expected grant=%b owner=%0d gv=%b busy=%b tmo=%b cyc=%0d",
                          grant, bus_owner, grant_valid, bus_busy, timeout, cyc,
                          mon_e.grant, mon_e.owner, mon_e.gv, mon_e.busy, mon_e.tmo, mon_e.at));
        end
        mon_prev = mon_cur;
      end
      @(negedge clk or negedge reset);
    end
  end

  // --------------------------------------------------------------- stimulus
  int b;
  int g;

  initial begin : stimulus
    reset   = 1'b0;
    request = 3'b111;
    iframe  = 1'b1;
    iready  = 1'b1;
    expect_ev("reset_state", 3'b111, 0, 1'b0, 1'b0, 1'b0, -1);
    at_cycle(3);
    reset = 1'b1;

    // Round robin from reset: owners 0,1,2,0, each with a 4-cycle frame.
    at_cycle(4);
    b       = cyc;
    request = 3'b000;
    for (int k = 0; k < 4; k++) begin
      g = b + 1 + 7 * k;
      expect_ev($sformatf("rr%0d_grant", k),   RR_GRANT[k], RR_OWNER[k], 1'b1, 1'b0, 1'b0, g);
      expect_ev($sformatf("rr%0d_busy", k),    RR_GRANT[k], RR_OWNER[k], 1'b1, 1'b1, 1'b0, g + 1);
      expect_ev($sformatf("rr%0d_release", k), 3'b111,      0,           1'b0, 1'b0, 1'b0, g + 5);
      at_cycle(g);
      iframe = 1'b0;
      iready = 1'b0;
      at_cycle(g + 3);
      iframe = 1'b1;
      at_cycle(g + 4);
      iready = 1'b1;
      if (k == 3) request = 3'b111;
    end

    // Single requester: grant, frame, idle, one turnaround cycle, re-grant,
    // then drop the request.
    at_cycle(cyc + 3);
    b       = cyc;
    request = 3'b110;
    expect_ev("single_grant",   3'b110, 0, 1'b1, 1'b0, 1'b0, b + 1);
    expect_ev("single_busy",    3'b110, 0, 1'b1, 1'b1, 1'b0, b + 4);
    expect_ev("single_release", 3'b111, 0, 1'b0, 1'b0, 1'b0, b + 7);
    expect_ev("single_regrant", 3'b110, 0, 1'b1, 1'b0, 1'b0, b + 9);
    expect_ev("single_drop",    3'b111, 0, 1'b0, 1'b0, 1'b0, b + 10);
    at_cycle(b + 3);
    iframe = 1'b0;
    iready = 1'b0;
    at_cycle(b + 5);
    iframe = 1'b1;
    at_cycle(b + 6);
    iready = 1'b1;
    at_cycle(b + 9);
    request = 3'b111;

    // Timeout on master 1 (8 grant cycles, one-cycle pulse); master 1 then
    // loses priority to master 2; master 2 withdraws its request unused.
    at_cycle(cyc + 2);
    b       = cyc;
    request = 3'b101;
    expect_ev("timeout_grant",  3'b101, 1, 1'b1, 1'b0, 1'b0, b + 1);
    expect_ev("timeout_pulse",  3'b111, 0, 1'b0, 1'b0, 1'b1, b + 9);
    expect_ev("after_timeout",  3'b011, 2, 1'b1, 1'b0, 1'b0, b + 10);
    expect_ev("withdraw_m2",    3'b111, 0, 1'b0, 1'b0, 1'b0, b + 13);
    at_cycle(b + 9);
    request = 3'b001;
    at_cycle(b + 12);
    request = 3'b111;

    // iframe low in the cycle the timer reaches its limit: start wins.
    at_cycle(cyc + 2);
    b       = cyc;
    request = 3'b110;
    expect_ev("race_grant", 3'b110, 0, 1'b1, 1'b0, 1'b0, b + 1);
    expect_ev("race_busy",  3'b110, 0, 1'b1, 1'b1, 1'b0, b + 9);
    at_cycle(b + 8);
    iframe = 1'b0;
    iready = 1'b0;

    // Asynchronous reset in the middle of the transaction, then master 0
    // must win first again.
    expect_ev("async_reset",      3'b111, 0, 1'b0, 1'b0, 1'b0, b + 10);
    expect_ev("post_reset_grant", 3'b110, 0, 1'b1, 1'b0, 1'b0, b + 12);
    expect_ev("post_reset_drop",  3'b111, 0, 1'b0, 1'b0, 1'b0, b + 13);
    at_cycle(b + 10);
    #2;
    reset   = 1'b0;
    iframe  = 1'b1;
    iready  = 1'b1;
    request = 3'b000;
    at_cycle(b + 11);
    reset = 1'b1;
    at_cycle(b + 12);
    request = 3'b111;

    at_cycle(b + 16);
    #2;
    check("all_expected_changes_seen", exp_q.size() == 0,
          $sformatf("got %0d expected changes still pending, need 0", exp_q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
